// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// Holds the scheduler FSM state type and the two-bit baud codes that the
// shared baud divider understands.
package uart_tx_pkg;

   // Scheduler FSM: wait for a requester, let the divider settle, kick the
   // transmitter, then wait for it to finish the byte.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_START  = 2'd2,
      ST_WAIT   = 2'd3
   } sched_state_t;

   // Baud codes as seen by the shared divider.
   localparam logic [1:0] BAUD_1200 = 2'b00;
   localparam logic [1:0] BAUD_2400 = 2'b01;
   localparam logic [1:0] BAUD_4800 = 2'b10;
   localparam logic [1:0] BAUD_9600 = 2'b11;

   // The divider idles at the fastest rate, so that is the value it holds
   // before any requester has been served.
   localparam logic [1:0] BAUD_DEFAULT = BAUD_9600;

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Round-robin arbiter for the UART transmit scheduler.
// Given the index of the last winner, it picks the first active request at
// the next index onwards, wrapping from N-1 back to 0. Purely combinational;
// the caller owns the pointer register.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] pointer,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] grant_idx,
   output logic          valid
);

   int            cand;
   logic [PW-1:0] cand_idx;

   // Scan the N candidates in priority order, starting just after the pointer.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      valid     = 1'b0;
      cand      = 0;
      cand_idx  = '0;
      for (int k = 1; k <= N; k++) begin
         cand = int'(pointer) + k;
         if (cand >= N) begin
            cand = cand - N;
         end
         cand_idx = PW'(cand);
         if (!valid && req[cand_idx]) begin
            valid           = 1'b1;
            grant_idx       = cand_idx;
            grant[cand_idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// UART transmit scheduler: shares one transmitter and one baud divider
// between NREQ requesters. A winner is picked round-robin, its byte and baud
// code are latched, the divider is given SETTLE_CYC cycles to lock onto the
// new rate, and then the transmitter is started and awaited.
// Optional feature: define UART_TX_SCHED_TIMEOUT_EN to add a watchdog that
// abandons a transfer after TIMEOUT_CYC cycles without tx_done.
module uart_tx_sched #(
   parameter int NREQ        = 4,
   parameter int SETTLE_CYC  = 4,
   parameter int TIMEOUT_CYC = 2_000_000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [8*NREQ-1:0] req_data,
   input  logic [2*NREQ-1:0] req_baud,
   output logic [NREQ-1:0]   gnt,
   output logic [1:0]        bd_rate,
   output logic              sys_clk_call,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   input  logic              tx_done,
   output logic              busy,
   output logic              timeout
);

   import uart_tx_pkg::*;

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int SW = $clog2(SETTLE_CYC + 1);

   sched_state_t  state;
   sched_state_t  state_nxt;
   logic [PW-1:0] ptr;
   logic [SW-1:0] settle_cnt;
   logic          settle_done;

   logic [NREQ-1:0] arb_grant;
   logic [PW-1:0]   arb_idx;
   logic            arb_valid;
   logic            take;
   logic [7:0]      sel_data;
   logic [1:0]      sel_baud;

`ifdef UART_TX_SCHED_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT_CYC + 1);
   logic [WW-1:0] wd_cnt;
   logic          wd_expired;
   logic          timeout_pulse;
`endif

   rr_arbiter #(
      .N  (NREQ),
      .PW (PW)
   ) u_arb (
      .req       (req),
      .pointer   (ptr),
      .grant     (arb_grant),
      .grant_idx (arb_idx),
      .valid     (arb_valid)
   );

   // Pick out the winner's byte and baud code from the packed request buses.
   always_comb begin
      sel_data = '0;
      sel_baud = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (arb_grant[i]) begin
            sel_data = req_data[8*i +: 8];
            sel_baud = req_baud[2*i +: 2];
         end
      end
   end

   assign take        = (state == ST_IDLE) && arb_valid;
   assign settle_done = (settle_cnt == SW'(SETTLE_CYC - 1));

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Accepted byte, its baud code and the round-robin pointer only change at
   // a grant, so later request activity cannot disturb a transfer in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr     <= PW'(NREQ - 1);
         tx_data <= '0;
         bd_rate <= BAUD_DEFAULT;
      end else if (take) begin
         ptr     <= arb_idx;
         tx_data <= sel_data;
         bd_rate <= sel_baud;
      end
   end

   // Settle counter runs only while the divider is locking onto the new rate.
   always_ff @(posedge clk) begin
      if (rst) begin
         settle_cnt <= '0;
      end else if (state == ST_SETTLE) begin
         settle_cnt <= settle_cnt + 1'b1;
      end else begin
         settle_cnt <= '0;
      end
   end

`ifdef UART_TX_SCHED_TIMEOUT_EN
   // Watchdog counts cycles spent waiting on the transmitter.
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt <= '0;
      end else if (state == ST_WAIT) begin
         wd_cnt <= wd_cnt + 1'b1;
      end else begin
         wd_cnt <= '0;
      end
   end

   assign wd_expired = (wd_cnt == WW'(TIMEOUT_CYC - 1));
   assign timeout    = timeout_pulse;
`else
   assign timeout = 1'b0;
`endif

   // Next-state and handshake outputs; gnt is issued in the IDLE cycle that
   // sees the request, so the start pulse lands SETTLE_CYC+1 cycles later.
   always_comb begin
      state_nxt    = state;
      gnt          = '0;
      tx_start     = 1'b0;
      sys_clk_call = 1'b1;
      busy         = 1'b1;
`ifdef UART_TX_SCHED_TIMEOUT_EN
      timeout_pulse = 1'b0;
`endif
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (arb_valid && !rst) begin
               gnt       = arb_grant;
               state_nxt = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (settle_done) begin
               state_nxt = ST_START;
            end
         end
         ST_START: begin
            tx_start     = 1'b1;
            sys_clk_call = 1'b0;
            state_nxt    = ST_WAIT;
         end
         ST_WAIT: begin
            sys_clk_call = 1'b0;
            if (tx_done) begin
               state_nxt = ST_IDLE;
            end
`ifdef UART_TX_SCHED_TIMEOUT_EN
            else if (wd_expired) begin
               timeout_pulse = 1'b1;
               state_nxt     = ST_IDLE;
            end
`endif
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters (2..8).
REQ-002 SHALL have parameter SETTLE_CYC, default 4: clk cycles baud select is held stable before start.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 2_000_000: WAIT watchdog limit, used only under the macro.
REQ-004 SHALL have one clock and a synchronous active-high reset: clk  in  1  system clock 50 MHz; rst  in  1  synchronous active-high reset.
REQ-005 SHALL have port req  in  NREQ  per-requester transmit request, level.
REQ-006 SHALL have port req_data  in  8*NREQ  byte per requester, slice i = [8i+7:8i].
REQ-007 SHALL have port req_baud  in  2*NREQ  baud code per requester (00=1200, 01=2400, 10=4800, 11=9600).
REQ-008 SHALL have port gnt  out  NREQ  one-hot, one-cycle acknowledge when a requester's byte is accepted.
REQ-009 SHALL have port bd_rate  out  2  baud code driven to the shared divider.
REQ-010 SHALL have port sys_clk_call  out  1  divider bypass/hold, high while not transmitting.
REQ-011 SHALL have port tx_start  out  1  one-cycle start pulse to the transmitter.
REQ-012 SHALL have port tx_data  out  8  byte to the transmitter, stable from tx_start until tx_done.
REQ-013 SHALL have port tx_done  in  1  one-cycle completion pulse from the transmitter.
REQ-014 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-015 SHALL have port timeout  out  1  one-cycle pulse on watchdog expiry (tied 0 without the macro).

Function
REQ-016 SHALL implement the FSM IDLE -> SETTLE -> START -> WAIT -> IDLE.
REQ-017 In IDLE with any req high, it SHALL grant round-robin starting from the index after the last granted one, pulse gnt for that index, latch its data and baud, and go to SETTLE next cycle.
REQ-018 In IDLE with no req, it SHALL stay in IDLE; the round-robin pointer SHALL not move.
REQ-019 In SETTLE, it SHALL drive the latched bd_rate, keep sys_clk_call high, and count SETTLE_CYC cycles, then go to START.
REQ-020 In START, it SHALL pulse tx_start for exactly one cycle, drop sys_clk_call, and go to WAIT.
REQ-021 In WAIT, sys_clk_call SHALL be low and bd_rate and tx_data SHALL stay constant; on tx_done it SHALL return to IDLE.
REQ-022 Grant-to-tx_start latency SHALL be SETTLE_CYC+1 cycles.
REQ-023 Req changes during SETTLE/START/WAIT SHALL NOT affect the latched data or baud.
REQ-024 A tx_done outside WAIT SHALL be ignored.
REQ-025 A tx_done coinciding with a new req SHALL return to IDLE first; the new grant is issued no earlier than the following cycle.
REQ-026 The round-robin pointer SHALL wrap from NREQ-1 to 0.

Reset
REQ-027 With rst high at a clk edge, the block SHALL go to IDLE with pointer=NREQ-1 (index 0 wins first), gnt=0, tx_start=0, tx_data=0, bd_rate=2'b11, sys_clk_call=1, busy=0, timeout=0.
REQ-028 Reset mid-transfer SHALL abandon the transfer with no gnt or tx_start issued afterwards.

Configuration
REQ-029 With macro UART_TX_SCHED_TIMEOUT_EN defined, WAIT SHALL count cycles and, at TIMEOUT_CYC without tx_done, pulse timeout for one cycle and return to IDLE.
REQ-030 Without UART_TX_SCHED_TIMEOUT_EN, there SHALL be no watchdog counter, WAIT SHALL wait indefinitely, and timeout SHALL be constant 0.

Structure
REQ-031 The shared package uart_tx_pkg SHALL hold the FSM state type and the baud code constants (BAUD_1200..BAUD_9600).
REQ-032 Round-robin selection SHALL be a sub-module rr_arbiter (req, pointer -> one-hot grant, valid).

Verification
REQ-033 Scenario single request: reset, req=0001, data0=0x55, baud0=01 -> gnt=0001 one cycle; bd_rate=01; tx_start 5 cycles later with tx_data=0x55; tx_done -> busy=0.
REQ-034 Scenario fairness: req=1111 held, tx_done 10 cycles after each start -> grant order 0,1,2,3,0.
REQ-035 Scenario mid-transfer change: req0 baud=11, change req_data0 and baud0 during WAIT -> tx_data and bd_rate unchanged until tx_done.
REQ-036 Scenario stray done: tx_done pulse in IDLE and in SETTLE -> no state change, tx_start still issued on schedule.
REQ-037 Scenario reset in WAIT: rst in WAIT -> all outputs at reset values next cycle, no tx_start afterwards until a new req.
REQ-038 Scenario watchdog, macro defined with TIMEOUT_CYC=100: no tx_done -> timeout pulse 100 cycles into WAIT, then IDLE; macro undefined -> stays in WAIT and timeout=0.
